// File: rtl/seg_execute_ex_mem_latch.sv
// rtl/seg_execute_ex_mem_latch.sv - EX/MEM pipeline latch with flush, stall and retired-instruction counter
module seg_execute_ex_mem_latch #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_COUNT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [NB_DATA-1:0]  i_ALUOut,
    input  logic                i_zero,
    input  logic [NB_DATA-1:0]  i_data_b,
    input  logic [NB_ADDR-1:0]  i_branch_target,
    input  logic [NB_REG-1:0]   i_rd,
    input  logic [4:0]          i_ctl,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_ALUOut,
    output logic [NB_DATA-1:0]  o_data_b,
    output logic [NB_ADDR-1:0]  o_branch_target,
    output logic [NB_REG-1:0]   o_rd,
    output logic                o_RegWrite,
    output logic                o_MemtoReg,
    output logic                o_MemRead,
    output logic                o_MemWrite,
    output logic                o_PCSrc,
    output logic [NB_COUNT-1:0] o_retired
);

    // i_ctl = {RegWrite, MemtoReg, MemRead, MemWrite, Branch}
    logic reg_write_in;
    logic mem_to_reg_in;
    logic mem_read_in;
    logic mem_write_in;
    logic pc_src_in;

    // Bubbles never carry control, so unknown control/zero bits cannot leak.
    always_comb begin
        reg_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        pc_src_in     = 1'b0;
        if (i_valid) begin
            reg_write_in  = i_ctl[4];
            mem_to_reg_in = i_ctl[3];
            mem_read_in   = i_ctl[2];
            mem_write_in  = i_ctl[1];
            pc_src_in     = i_ctl[0] & i_zero;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid         <= 1'b0;
            o_ALUOut        <= '0;
            o_data_b        <= '0;
            o_branch_target <= '0;
            o_rd            <= '0;
            o_RegWrite      <= 1'b0;
            o_MemtoReg      <= 1'b0;
            o_MemRead       <= 1'b0;
            o_MemWrite      <= 1'b0;
            o_PCSrc         <= 1'b0;
            o_retired       <= '0;
        end else if (i_flush) begin
            // Data fields keep their last values; only the control side becomes a bubble.
            o_valid    <= 1'b0;
            o_RegWrite <= 1'b0;
            o_MemtoReg <= 1'b0;
            o_MemRead  <= 1'b0;
            o_MemWrite <= 1'b0;
            o_PCSrc    <= 1'b0;
        end else if (!i_stall) begin
            o_valid         <= i_valid;
            o_ALUOut        <= i_ALUOut;
            o_data_b        <= i_data_b;
            o_branch_target <= i_branch_target;
            o_rd            <= i_rd;
            o_RegWrite      <= reg_write_in;
            o_MemtoReg      <= mem_to_reg_in;
            o_MemRead       <= mem_read_in;
            o_MemWrite      <= mem_write_in;
            o_PCSrc         <= pc_src_in;
            if (i_valid) begin
                o_retired <= o_retired + 1'b1;
            end
        end
    end

endmodule

// File: doc/seg_execute_ex_mem_latch.md
SEG_EXECUTE_EX_MEM_LATCH -- requirements
Module: seg_execute_ex_mem_latch

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: ALU result and store-data width.
REQ-002 SHALL have parameter NB_ADDR, default 32: branch-target width.
REQ-003 SHALL have parameter NB_REG, default 5: destination register index width.
REQ-004 SHALL have parameter NB_COUNT, default 16: retired-instruction counter width.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_valid, input, 1: the execute stage presents a real instruction.
REQ-008 SHALL have port i_stall, input, 1: hold all registered outputs.
REQ-009 SHALL have port i_flush, input, 1: load a bubble.
REQ-010 SHALL have port i_ALUOut, input, NB_DATA: result from the execute ALU.
REQ-011 SHALL have port i_zero, input, 1: ALU zero flag.
REQ-012 SHALL have port i_data_b, input, NB_DATA: store data (forwarded rt value).
REQ-013 SHALL have port i_branch_target, input, NB_ADDR: computed branch address.
REQ-014 SHALL have port i_rd, input, NB_REG: destination register.
REQ-015 SHALL have port i_ctl, input, 5: {RegWrite, MemtoReg, MemRead, MemWrite, Branch}.
REQ-016 SHALL have ports o_valid (1), o_ALUOut (NB_DATA), o_data_b (NB_DATA), o_branch_target (NB_ADDR), o_rd (NB_REG), o_RegWrite, o_MemtoReg, o_MemRead, o_MemWrite (1 each), all outputs: registered copies for the MEM stage.
REQ-017 SHALL have port o_PCSrc, output, 1: registered branch-taken, equal to Branch AND zero.
REQ-018 SHALL have port o_retired, output, NB_COUNT: count of instructions loaded.

Function
REQ-019 SHALL choose one action per rising edge, in priority order: reset > flush > stall > load.
REQ-020 Load (no reset, flush or stall): every output register SHALL take its input, o_valid SHALL take i_valid, and o_PCSrc SHALL take i_ctl[0] & i_zero; latency is exactly 1 cycle.
REQ-021 On load with i_valid=0, the control outputs (o_RegWrite, o_MemtoReg, o_MemRead, o_MemWrite, o_PCSrc) SHALL be forced to 0, whatever i_ctl is.
REQ-022 Stall: all outputs, o_retired included, SHALL hold their previous values.
REQ-023 Flush: o_valid and all control outputs SHALL become 0; data outputs (o_ALUOut, o_data_b, o_branch_target, o_rd) SHALL hold.
REQ-024 Flush and stall both asserted: flush SHALL win.
REQ-025 o_retired SHALL increment by 1 only on a load with i_valid=1.
REQ-026 o_retired SHALL wrap modulo 2^NB_COUNT (all ones + 1 -> 0) with no saturation and no flag.
REQ-027 No output SHALL depend combinationally on any input.
REQ-028 X on data inputs while the instruction is a bubble SHALL NOT propagate to the control outputs.

Reset
REQ-029 With i_rst=1 at a rising edge, every output including o_retired SHALL be 0 after that edge, whatever i_flush, i_stall and i_valid are.
REQ-030 Reset asserted mid-stream SHALL discard the instruction presented that cycle; the first load after i_rst deasserts SHALL behave as in REQ-020.

Verification
REQ-031 Reset scenario: hold i_rst=1 for 2 cycles with i_valid=1 and i_ctl=5'b11111 -> all outputs 0 and o_retired=0.
REQ-032 Branch scenario: i_valid=1, i_ALUOut=32'h0000_0010, i_zero=1, i_ctl=5'b00001, i_branch_target=32'h40 -> next cycle o_PCSrc=1, o_branch_target=32'h40, o_ALUOut=32'h10, o_retired=1.
REQ-033 Stall scenario: after a load of i_rd=5'd7 with RegWrite=1, hold i_stall=1 for 3 cycles while i_rd=5'd9 -> o_rd stays 7, o_RegWrite stays 1, o_retired unchanged.
REQ-034 Flush scenario: assert i_flush and i_stall together while valid i_ctl=5'b10100 is presented -> o_valid=0, all control outputs 0, o_ALUOut holds its prior value, o_retired unchanged.
REQ-035 Wrap scenario: with NB_COUNT=4, perform 17 valid loads -> o_retired reads 15 after the 15th load, 0 after the 16th, 1 after the 17th.
REQ-036 Bubble scenario: load with i_valid=0 and i_ctl=5'b11111 -> o_valid=0, all control outputs 0, o_retired unchanged.
